cache_mem_arbiter: RTL and testbench

// - Shares one line-wide memory port between two direct-mapped cache controllers (req0, req1).
// - Sits between the caches' cache2mem/mem2cache handshake and the memory model/controller.
// - Grants round-robin, holds the grant until memory completes, and routes the ready and read data back.

---
 rtl/cache_arb_pkg.sv | 15 +
 rtl/cache_mem_arbiter_rr_pick2.sv | 24 ++
 rtl/cache_mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/cache_arb_pkg.sv
// Purpose : shared types and widths for the cache-to-memory arbiter.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: arb_state_t (IDLE/BUSY), ARB_ADDR_W, ARB_LINE_W.
package cache_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_LINE_W = 128;

endpackage

// File: rtl/cache_mem_arbiter_rr_pick2.sv
// Purpose : two-way round-robin pick; chooses which requester wins this cycle.
// Latency : purely combinational.
// Backpressure: none; caller decides when the pick is consumed.
// Ports   : i_valid[1:0] requests, i_rr_ptr preferred index when both request;
//           o_any = some request present, o_winner = chosen index.
module rr_pick2 (
  input  logic [1:0] i_valid,
  input  logic       i_rr_ptr,
  output logic       o_any,
  output logic       o_winner
);

  always_comb begin
    o_any    = |i_valid;
    o_winner = 1'b0;
    case (i_valid)
      2'b01:   o_winner = 1'b0;
      2'b10:   o_winner = 1'b1;
      2'b11:   o_winner = i_rr_ptr;  // contention: the pointer decides
      default: o_winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Purpose : shares one line-wide memory port between two cache controllers, round-robin.
// Latency : request seen in cycle N -> arb2mem_valid in cycle N+1; ready returns in the
//           cycle memory pulses mem2arb_ready.
// Backpressure: a requester holds valid until its one-cycle ready pulse; the grant is held
//           until memory completes, so the other requester waits.
// Ports   : clk/rst (sync, active-high); req0_*/req1_* cache side (valid/rw/addr/wdata in,
//           ready/rdata out); arb2mem_* registered memory request; mem2arb_data/ready memory
//           response; arb_busy, arb_grant status; perf_grant0/1 grant counters.
// Config  : define ARB_PERF_EN to build saturating grant counters; otherwise the perf
//           ports read 0 and no counter registers exist.
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int LINE_W = ARB_LINE_W
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0_valid,
  input  logic              req0_rw,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [LINE_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic [LINE_W-1:0] req0_rdata,

  input  logic              req1_valid,
  input  logic              req1_rw,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [LINE_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic [LINE_W-1:0] req1_rdata,

  output logic              arb2mem_valid,
  output logic              arb2mem_rw,
  output logic [ADDR_W-1:0] arb2mem_addr,
  output logic [LINE_W-1:0] arb2mem_data,
  input  logic [LINE_W-1:0] mem2arb_data,
  input  logic              mem2arb_ready,

  output logic              arb_busy,
  output logic              arb_grant,
  output logic [31:0]       perf_grant0,
  output logic [31:0]       perf_grant1
);

  arb_state_t        r_state;
  logic              r_rr_ptr;
  logic              r_grant;
  logic              r_busy;
  logic              r_mem_valid;
  logic              r_mem_rw;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [LINE_W-1:0] r_mem_data;

  logic              w_any;
  logic              w_winner;
  logic              w_sel_rw;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [LINE_W-1:0] w_sel_data;
  logic              w_done;

  rr_pick2 u_pick (
    .i_valid  ({req1_valid, req0_valid}),
    .i_rr_ptr (r_rr_ptr),
    .o_any    (w_any),
    .o_winner (w_winner)
  );

  assign w_sel_rw   = w_winner ? req1_rw    : req0_rw;
  assign w_sel_addr = w_winner ? req1_addr  : req0_addr;
  assign w_sel_data = w_winner ? req1_wdata : req0_wdata;

  // Completion is only honoured in BUSY; a stray memory pulse in IDLE is dropped, and a
  // reset in the completion cycle abandons the transaction without a ready pulse.
  assign w_done = (r_state == ARB_BUSY) && mem2arb_ready && !rst;

  // Single FSM; everything it drives is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ARB_IDLE;
      r_rr_ptr    <= 1'b0;
      r_grant     <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_rw    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_any) begin
            r_state     <= ARB_BUSY;
            r_busy      <= 1'b1;
            r_grant     <= w_winner;
            r_mem_valid <= 1'b1;
            r_mem_rw    <= w_sel_rw;
            r_mem_addr  <= w_sel_addr;
            r_mem_data  <= w_sel_data;
          end
        end
        ARB_BUSY: begin
          // Requester inputs are not looked at here: the latched request stays put.
          if (mem2arb_ready) begin
            r_state     <= ARB_IDLE;
            r_busy      <= 1'b0;
            r_mem_valid <= 1'b0;
            r_rr_ptr    <= ~r_grant;  // the other side gets priority next time
          end
        end
        default: begin
          r_state <= ARB_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign arb2mem_valid = r_mem_valid;
  assign arb2mem_rw    = r_mem_rw;
  assign arb2mem_addr  = r_mem_addr;
  assign arb2mem_data  = r_mem_data;
  assign arb_busy      = r_busy;
  assign arb_grant     = r_grant;

  assign req0_ready = w_done && (r_grant == 1'b0);
  assign req1_ready = w_done && (r_grant == 1'b1);
  // Read data fans out to both; only the side seeing ready consumes it.
  assign req0_rdata = mem2arb_data;
  assign req1_rdata = mem2arb_data;

`ifdef ARB_PERF_EN
  logic [31:0] r_perf0;
  logic [31:0] r_perf1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf0 <= 32'd0;
      r_perf1 <= 32'd0;
    end else if (r_state == ARB_IDLE && w_any) begin
      if (!w_winner && r_perf0 != 32'hFFFF_FFFF) r_perf0 <= r_perf0 + 32'd1;
      if ( w_winner && r_perf1 != 32'hFFFF_FFFF) r_perf1 <= r_perf1 + 32'd1;
    end
  end

  assign perf_grant0 = r_perf0;
  assign perf_grant1 = r_perf1;
`else
  assign perf_grant0 = 32'd0;
  assign perf_grant1 = 32'd0;
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Purpose : directed, table-driven check of cache_mem_arbiter plus a grant-count sequence.
// Latency : inputs driven 1 time unit after posedge, outputs sampled mid-cycle.
// Backpressure: the bench plays both caches and the memory.
module tb_cache_mem_arbiter;

  localparam logic [127:0] Z  = 128'h0;
  localparam logic [127:0] A5 = {16{8'hA5}};
  localparam logic [127:0] BB = {16{8'h3C}};
  localparam logic [127:0] DB = {4{32'hDEADBEEF}};

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_rw, req1_valid, req1_rw;
  logic [31:0]  req0_addr, req1_addr;
  logic [127:0] req0_wdata, req1_wdata;
  logic         req0_ready, req1_ready;
  logic [127:0] req0_rdata, req1_rdata;
  logic         arb2mem_valid, arb2mem_rw;
  logic [31:0]  arb2mem_addr;
  logic [127:0] arb2mem_data;
  logic [127:0] mem2arb_data;
  logic         mem2arb_ready;
  logic         arb_busy, arb_grant;
  logic [31:0]  perf_grant0, perf_grant1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_rdata(req1_rdata),
    .arb2mem_valid(arb2mem_valid), .arb2mem_rw(arb2mem_rw), .arb2mem_addr(arb2mem_addr),
    .arb2mem_data(arb2mem_data), .mem2arb_data(mem2arb_data), .mem2arb_ready(mem2arb_ready),
    .arb_busy(arb_busy), .arb_grant(arb_grant),
    .perf_grant0(perf_grant0), .perf_grant1(perf_grant1)
  );

  typedef struct {
    logic         rst;
    logic         v0, rw0;  logic [31:0] a0;  logic [127:0] wd0;
    logic         v1, rw1;  logic [31:0] a1;  logic [127:0] wd1;
    logic         mr;       logic [127:0] md;
    logic         e_mv, e_rw; logic [31:0] e_addr; logic [127:0] e_data;
    logic         e_busy, e_grant, e_r0, e_r1; logic [127:0] e_rd;
  } vec_t;

  localparam int NV = 26;
  vec_t vec [NV];

  task automatic vi(input int i, input logic rs, input logic v0, input logic rw0,
                    input logic [31:0] a0, input logic [127:0] wd0, input logic v1,
                    input logic rw1, input logic [31:0] a1, input logic [127:0] wd1,
                    input logic mr, input logic [127:0] md);
    vec[i].rst = rs;
    vec[i].v0 = v0; vec[i].rw0 = rw0; vec[i].a0 = a0; vec[i].wd0 = wd0;
    vec[i].v1 = v1; vec[i].rw1 = rw1; vec[i].a1 = a1; vec[i].wd1 = wd1;
    vec[i].mr = mr; vec[i].md = md;
  endtask

  task automatic ve(input int i, input logic mv, input logic rw, input logic [31:0] addr,
                    input logic [127:0] data, input logic busy, input logic grant,
                    input logic r0, input logic r1, input logic [127:0] rd);
    vec[i].e_mv = mv; vec[i].e_rw = rw; vec[i].e_addr = addr; vec[i].e_data = data;
    vec[i].e_busy = busy; vec[i].e_grant = grant; vec[i].e_r0 = r0; vec[i].e_r1 = r1;
    vec[i].e_rd = rd;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst;
    req0_valid = v.v0; req0_rw = v.rw0; req0_addr = v.a0; req0_wdata = v.wd0;
    req1_valid = v.v1; req1_rw = v.rw1; req1_addr = v.a1; req1_wdata = v.wd1;
    mem2arb_ready = v.mr; mem2arb_data = v.md;
  endtask

  // One whole transaction for requester idx, memory answering in the first BUSY cycle.
  task automatic txn(input int idx);
    logic [1:0] exp_rdy;
    exp_rdy = (idx == 0) ? 2'b10 : 2'b01;
    if (idx == 0) req0_valid = 1'b1; else req1_valid = 1'b1;
    req0_addr = 32'h300; req1_addr = 32'h304;
    @(posedge clk); #1;
    chk($sformatf("txn%0d_grant", idx), {254'd0, arb2mem_valid, arb_grant},
        {254'd0, 1'b1, (idx != 0)});
    mem2arb_ready = 1'b1; mem2arb_data = BB;
    #4;
    chk($sformatf("txn%0d_ready", idx), {254'd0, req0_ready, req1_ready}, {254'd0, exp_rdy});
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; mem2arb_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] exp_p0, exp_p1;

    //            rst v0 rw0 a0       wd0 v1 rw1 a1        wd1 mr md
    // Single read by req0, then drop on ready
    vi( 0, 0, 1, 0, 32'h40,  Z, 0, 0, 32'h0,    Z,  0, Z);  ve( 0, 0,0,32'h0,   Z, 0,0,0,0,Z);
    vi( 1, 0, 1, 0, 32'h40,  Z, 0, 0, 32'h0,    Z,  0, Z);  ve( 1, 1,0,32'h40,  Z, 1,0,0,0,Z);
    vi( 2, 0, 1, 0, 32'h40,  Z, 0, 0, 32'h0,    Z,  1, A5); ve( 2, 1,0,32'h40,  Z, 1,0,1,0,A5);
    vi( 3, 0, 0, 0, 32'h0,   Z, 0, 0, 32'h0,    Z,  0, Z);  ve( 3, 0,0,32'h40,  Z, 0,0,0,0,Z);
    // Reset dominates requests; then both request at once
    vi( 4, 1, 1, 0, 32'h100, Z, 1, 0, 32'h200,  Z,  0, Z);  ve( 4, 0,0,32'h40,  Z, 0,0,0,0,Z);
    vi( 5, 0, 1, 0, 32'h100, Z, 1, 0, 32'h200,  Z,  0, Z);  ve( 5, 0,0,32'h0,   Z, 0,0,0,0,Z);
    vi( 6, 0, 1, 0, 32'h100, Z, 1, 0, 32'h200,  Z,  1, BB); ve( 6, 1,0,32'h100, Z, 1,0,1,0,BB);
    // req0 re-requests at once, but the pointer now favours req1
    vi( 7, 0, 1, 0, 32'h104, Z, 1, 0, 32'h200,  Z,  0, Z);  ve( 7, 0,0,32'h100, Z, 0,0,0,0,Z);
    vi( 8, 0, 1, 0, 32'h104, Z, 1, 0, 32'h200,  Z,  1, A5); ve( 8, 1,0,32'h200, Z, 1,1,0,1,A5);
    vi( 9, 0, 1, 0, 32'h104, Z, 0, 0, 32'h0,    Z,  0, Z);  ve( 9, 0,0,32'h200, Z, 0,1,0,0,Z);
    vi(10, 0, 1, 0, 32'h104, Z, 0, 0, 32'h0,    Z,  0, Z);  ve(10, 1,0,32'h104, Z, 1,0,0,0,Z);
    vi(11, 0, 1, 0, 32'h104, Z, 0, 0, 32'h0,    Z,  1, BB); ve(11, 1,0,32'h104, Z, 1,0,1,0,BB);
    // Write-back from req1 held through a 5-cycle wait while its inputs change
    vi(12, 0, 0, 0, 32'h0,   Z, 1, 1, 32'h1000, DB, 0, Z);  ve(12, 0,0,32'h104, Z, 0,0,0,0,Z);
    vi(13, 0, 0, 0, 32'h0,   Z, 1, 1, 32'h1000, DB, 0, Z);  ve(13, 1,1,32'h1000,DB,1,1,0,0,Z);
    vi(14, 0, 0, 0, 32'h0,   Z, 1, 1, 32'h1000, DB, 0, Z);  ve(14, 1,1,32'h1000,DB,1,1,0,0,Z);
    vi(15, 0, 0, 0, 32'h0,   Z, 1, 0, 32'h2000, Z,  0, Z);  ve(15, 1,1,32'h1000,DB,1,1,0,0,Z);
    vi(16, 0, 0, 0, 32'h0,   Z, 1, 0, 32'h2000, Z,  0, Z);  ve(16, 1,1,32'h1000,DB,1,1,0,0,Z);
    vi(17, 0, 0, 0, 32'h0,   Z, 1, 0, 32'h2000, Z,  0, Z);  ve(17, 1,1,32'h1000,DB,1,1,0,0,Z);
    vi(18, 0, 0, 0, 32'h0,   Z, 1, 1, 32'h1000, DB, 1, A5); ve(18, 1,1,32'h1000,DB,1,1,0,1,A5);
    // Stray memory ready in IDLE
    vi(19, 0, 0, 0, 32'h0,   Z, 0, 0, 32'h0,    Z,  1, BB); ve(19, 0,1,32'h1000,DB,0,1,0,0,Z);
    vi(20, 0, 0, 0, 32'h0,   Z, 0, 0, 32'h0,    Z,  0, Z);  ve(20, 0,1,32'h1000,DB,0,1,0,0,Z);
    // Address change while BUSY, then reset in the completion cycle
    vi(21, 0, 1, 0, 32'h40,  Z, 0, 0, 32'h0,    Z,  0, Z);  ve(21, 0,1,32'h1000,DB,0,1,0,0,Z);
    vi(22, 0, 1, 0, 32'h80,  Z, 0, 0, 32'h0,    Z,  0, Z);  ve(22, 1,0,32'h40,  Z, 1,0,0,0,Z);
    vi(23, 0, 1, 0, 32'h80,  Z, 0, 0, 32'h0,    Z,  0, Z);  ve(23, 1,0,32'h40,  Z, 1,0,0,0,Z);
    vi(24, 1, 1, 0, 32'h80,  Z, 0, 0, 32'h0,    Z,  1, A5); ve(24, 1,0,32'h40,  Z, 1,0,0,0,Z);
    vi(25, 0, 0, 0, 32'h0,   Z, 0, 0, 32'h0,    Z,  1, A5); ve(25, 0,0,32'h0,   Z, 0,0,0,0,Z);

    drive(vec[25]);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      drive(vec[i]);
      #4;
      chk($sformatf("vec%0d", i),
          {90'd0, arb2mem_valid, arb2mem_rw, arb2mem_addr, arb2mem_data,
           arb_busy, arb_grant, req0_ready, req1_ready},
          {90'd0, vec[i].e_mv, vec[i].e_rw, vec[i].e_addr, vec[i].e_data,
           vec[i].e_busy, vec[i].e_grant, vec[i].e_r0, vec[i].e_r1});
      if (vec[i].e_r0) chk($sformatf("vec%0d_rdata0", i), {128'd0, req0_rdata}, {128'd0, vec[i].e_rd});
      if (vec[i].e_r1) chk($sformatf("vec%0d_rdata1", i), {128'd0, req1_rdata}, {128'd0, vec[i].e_rd});
      @(posedge clk); #1;
    end

    // Grant counting after the reset at vector 24: three to req0, two to req1
    mem2arb_ready = 1'b0;
    txn(0); txn(1); txn(0); txn(1); txn(0);
`ifdef ARB_PERF_EN
    exp_p0 = 32'd3; exp_p1 = 32'd2;
`else
    exp_p0 = 32'd0; exp_p1 = 32'd0;
`endif
    chk("perf_grant0", {224'd0, perf_grant0}, {224'd0, exp_p0});
    chk("perf_grant1", {224'd0, perf_grant1}, {224'd0, exp_p1});
    chk("final_idle", {254'd0, arb_busy, arb2mem_valid}, 256'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
